// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution stream: frame geometry, data widths,
// writer FSM states and the pixel saturation helper used by front end and sink.
package conv_pkg;

    localparam int OUT_ROWS    = 23;
    localparam int OUT_COLS    = 30;
    localparam int IN_W        = 12;
    localparam int PIX_W       = 4;
    localparam int FRAME_BEATS = OUT_ROWS * OUT_COLS;
    localparam int ADDR_W      = $clog2(FRAME_BEATS);
    localparam int ROW_W       = $clog2(OUT_ROWS);
    localparam int COL_W       = $clog2(OUT_COLS);

    localparam logic signed [IN_W:0] PIX_MAX_EXT = (IN_W+1)'(2**PIX_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    // One extra magnitude bit so that negating the most negative input cannot overflow.
    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [IN_W-1:0] v,
                                                input logic abs_en);
        logic signed [IN_W:0] mag;
        mag = {v[IN_W-1], v};
        if (abs_en && mag[IN_W]) mag = -mag;
        if (mag[IN_W])                sat_pix = '0;
        else if (mag > PIX_MAX_EXT)   sat_pix = '1;
        else                          sat_pix = mag[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv_frame_ram.sv
// Result frame buffer: one write port, one registered read port (read-before-write),
// FRAME_BEATS entries of PIX_W bits addressed by row*OUT_COLS+col.
module conv_frame_ram
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [FRAME_BEATS];
    logic [PIX_W-1:0] rd_data_q, rd_data_d;

    // NOTE: the storage array has no reset so it maps onto plain RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = rd_zero ? '0 : mem[rd_addr];
    end

    // NOTE: non-blocking assignments here mean a same-cycle write is seen only on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_result_writer.sv
// Sink of the convolution stream: saturates each result to a pixel and stores a raster frame.
// Define CONV_WR_ABS_EN to store min(|in_data|, 2^PIX_W-1) (edge-magnitude mode) instead of clamping.
module conv_result_writer
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             rd_en,
    input  logic [4:0]       rd_row,
    input  logic [4:0]       rd_col,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ready
);

`ifdef CONV_WR_ABS_EN
    localparam logic ABS_MODE = 1'b1;
`else
    localparam logic ABS_MODE = 1'b0;
`endif

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

    wr_state_e        state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             frame_done_q, frame_done_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             wr_en;
    logic             rd_oob;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [PIX_W-1:0]  wr_pix;

    assign wr_pix  = sat_pix(in_data, ABS_MODE);
    assign wr_addr = ADDR_W'(row_q) * ADDR_W'(OUT_COLS) + ADDR_W'(col_q);
    assign rd_addr = ADDR_W'(rd_row) * ADDR_W'(OUT_COLS) + ADDR_W'(rd_col);
    assign rd_oob  = (rd_row >= 5'(OUT_ROWS)) || (rd_col >= 5'(OUT_COLS));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WRITE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            WRITE: begin
                if (start) begin
                    row_d = '0;
                    col_d = '0;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d        = '0;
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rd_err is held alongside rd_data when no read is issued.
    always_comb begin
        rd_valid_d = rd_en;
        rd_err_d   = rd_en ? rd_oob : rd_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
        end
    end

    conv_frame_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_pix),
        .rd_en   (rd_en),
        .rd_zero (rd_oob),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign in_ready    = (state_q == WRITE);
    assign busy        = (state_q == WRITE);
    assign frame_ready = (state_q == DONE);
    assign frame_done  = frame_done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer: random beats against a frame-level model,
// read responses checked by a separate monitor popping an expectation queue.
module tb_conv_result_writer;

    localparam int ROWS    = 23;
    localparam int COLS    = 30;
    localparam int BEATS   = ROWS * COLS;
    localparam int PMAX    = 15;
    localparam int S_IDLE  = 0;
    localparam int S_WRITE = 1;
    localparam int S_DONE  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_row = '0;
    logic [4:0]  rd_col = '0;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        busy;
    logic        frame_done;
    logic        frame_ready;

    conv_result_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_err      (rd_err),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        int data;
        bit chk;
    } rd_exp_t;

    rd_exp_t rdq[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      fd_count = 0;
    int      exp_done = 0;

    // Frame-level reference: a flat picture plus "which beat comes next".
    int m_state = S_IDLE;
    int m_k     = 0;
    int mem_m[BEATS];
    bit known[BEATS];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pix(input int v);
        int m;
        m = v;
`ifdef CONV_WR_ABS_EN
        if (m < 0) m = -m;
`endif
        if (m < 0) return 0;
        if (m > PMAX) return PMAX;
        return m;
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 40)) - 20;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // One clock of stimulus; expectations are formed before the edge, state checked after it.
    task automatic drive(input bit v, input int d, input bit st, input bit re, input int r, input int c);
        rd_exp_t e;
        bit      fin;
        int      idx;
        fin      = 1'b0;
        in_valid = v;
        in_data  = d[11:0];
        start    = st;
        rd_en    = re;
        rd_row   = r[4:0];
        rd_col   = c[4:0];
        if (re) begin
            e.err  = (r >= ROWS) || (c >= COLS);
            e.data = 0;
            e.chk  = 1'b1;
            if (!e.err) begin
                idx    = r * COLS + c;
                e.chk  = known[idx];
                e.data = mem_m[idx];
            end
            rdq.push_back(e);
        end
        if (st) begin
            m_state = S_WRITE;
            m_k     = 0;
        end else if (v && m_state == S_WRITE) begin
            mem_m[m_k] = ref_pix(d);
            known[m_k] = 1'b1;
            m_k++;
            if (m_k == BEATS) begin
                m_state = S_DONE;
                fin     = 1'b1;
                exp_done++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        rd_en    = 1'b0;
        check("in_ready", int'(in_ready), int'(m_state == S_WRITE));
        check("busy", int'(busy), int'(m_state == S_WRITE));
        check("frame_ready", int'(frame_ready), int'(m_state == S_DONE));
        check("frame_done", int'(frame_done), int'(fin));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) fd_count++;
            if (rd_valid) begin
                if (rdq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding at %0t", $time);
                end else begin
                    rd_exp_t e;
                    e = rdq.pop_front();
                    check("rd_err", int'(rd_err), int'(e.err));
                    if (e.chk) check("rd_data", int'(rd_data), e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sat_vals[4];
        sat_vals = '{-1, 8, 40, -2048};

        // Reset state
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_ready", int'(frame_ready), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_err", int'(rd_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Beats while IDLE are dropped
        for (int i = 0; i < 4; i++) drive(1'b1, i + 3, 1'b0, 1'b0, 0, 0);

        // Frame A: beat k carries k mod 16
        drive(1'b0, 0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < BEATS; k++) drive(1'b1, k % 16, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 29);
        drive(1'b0, 0, 1'b0, 1'b1, 22, 29);

        // Beats while DONE must not touch memory
        for (int i = 0; i < 5; i++) drive(1'b1, int'($urandom_range(0, 15)), 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b0, 1'b1, 0, i);

        // Out-of-range reads
        drive(1'b0, 0, 1'b0, 1'b1, 23, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 30);
        drive(1'b0, 0, 1'b0, 1'b1, 31, 31);
        drive(1'b0, 0, 1'b0, 1'b1, 22, 30);
        drive(1'b0, 0, 1'b0, 1'b1, 23, 29);

        // Frame B: saturation corners, then every-other-cycle valid with a collision at (5,5)
        drive(1'b0, 0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, sat_vals[i], 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, 1'b1, 0, i);
        for (int i = 0; i < 4000 && m_state != S_DONE; i++) begin
            if (i % 2 == 0 && m_k == 5 * COLS + 5) drive(1'b1, rnd_val(), 1'b0, 1'b1, 5, 5);
            else                                   drive(i % 2 == 0, rnd_val(), 1'b0, 1'b0, 0, 0);
        end
        drive(1'b0, 0, 1'b0, 1'b1, 5, 5);

        // Frame C: restart after 100 beats with a beat on the start cycle, then async reset
        drive(1'b0, 0, 1'b1, 1'b0, 0, 0);
        while (m_k < 100) drive(1'b1, rnd_val(), 1'b0, 1'b0, 0, 0);
        drive(1'b1, 7, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 9, 1'b0, 1'b0, 0, 0);
        while (m_k < 50) drive(1'b1, rnd_val(), 1'b0, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 1, 10);
        drive(1'b0, 0, 1'b0, 1'b1, 3, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_in_ready", int'(in_ready), 0);
        check("async_busy", int'(busy), 0);
        check("async_frame_ready", int'(frame_ready), 0);
        m_state = S_IDLE;
        m_k     = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_val(), 1'b0, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 0);

        // Frame D: random valid pattern, then random readback
        drive(1'b0, 0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6000 && m_state != S_DONE; i++)
            drive(bit'($urandom_range(0, 1)), rnd_val(), 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 40; i++)
            drive(1'b0, 0, 1'b0, 1'b1, int'($urandom_range(0, 24)), int'($urandom_range(0, 31)));
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        check("rd_queue_drained", rdq.size(), 0);
        check("frame_done_pulses", fd_count, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
